// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and a DMA/debug loader.
// Memory-side outputs and done pulses follow the owner combinationally within the busy cycle.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_err,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_done,
  output logic          dma_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          owner
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DMA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] wd_q, wd_d;

  logic busy_c;
  logic sel_dma_c;
  logic expire_c;
  logic finish_c;

  // Transaction status; reset masks everything so nothing leaks out during a reset cycle.
  always_comb begin
    busy_c    = (state_q != IDLE) && !reset;
    sel_dma_c = (state_q == BUSY_DMA);
    expire_c  = busy_c && !mem_ready && (wd_q == WD_LAST);
    finish_c  = busy_c && (mem_ready || (wd_q == WD_LAST));
  end

  // Next-state: grant from IDLE, otherwise wait for ready or watchdog expiry.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    wd_d         = wd_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (cpu_req && (!dma_req || last_owner_q)) begin
          state_d      = BUSY_CPU;
          last_owner_d = 1'b0;
        end else if (dma_req) begin
          state_d      = BUSY_DMA;
          last_owner_d = 1'b1;
        end
      end
      BUSY_CPU, BUSY_DMA: begin
        if (finish_c) begin
          state_d = IDLE;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
    end
  end

  // Memory request mux and completion pulses.
  always_comb begin
    mem_req   = busy_c;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (busy_c) begin
      if (sel_dma_c) begin
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end else begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end

    cpu_done  = finish_c && !sel_dma_c;
    dma_done  = finish_c && sel_dma_c;
    cpu_err   = expire_c && !sel_dma_c;
    dma_err   = expire_c && sel_dma_c;
    cpu_rdata = (cpu_done && !expire_c) ? mem_rdata : '0;
    dma_rdata = (dma_done && !expire_c) ? mem_rdata : '0;
  end

  assign owner = last_owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_done, cpu_err;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_done, dma_err;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          owner;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done), .dma_err(dma_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: one outstanding transaction (who, age) plus the last granted requester.
  bit m_busy, m_who, m_last;
  int m_age;
  bit e_cpu_done, e_dma_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle of outputs against the model, then advance the model on the clock edge.
  task automatic cycle();
    bit            act, fin, err;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    #1;
    act = m_busy && !reset;
    fin = act && (mem_ready || (m_age == int'(TO) - 1));
    err = fin && !mem_ready;
    we  = m_who ? dma_we : cpu_we;
    a   = m_who ? dma_addr : cpu_addr;
    wd  = m_who ? dma_wdata : cpu_wdata;
    rd  = (fin && !err) ? mem_rdata : '0;
    e_cpu_done = fin && !m_who;
    e_dma_done = fin && m_who;
    chk("mem_req",   64'(mem_req),   64'(act));
    chk("mem_we",    64'(mem_we),    64'(act ? we : 1'b0));
    chk("mem_addr",  64'(mem_addr),  64'(act ? a : '0));
    chk("mem_wdata", 64'(mem_wdata), 64'(act ? wd : '0));
    chk("cpu_done",  64'(cpu_done),  64'(e_cpu_done));
    chk("cpu_err",   64'(cpu_err),   64'(err && !m_who));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(m_who ? '0 : rd));
    chk("dma_done",  64'(dma_done),  64'(e_dma_done));
    chk("dma_err",   64'(dma_err),   64'(err && m_who));
    chk("dma_rdata", 64'(dma_rdata), 64'(m_who ? rd : '0));
    chk("owner",     64'(owner),     64'(m_last));
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_age  = 0;
    end else if (m_busy) begin
      if (fin) m_busy = 1'b0;
      else     m_age++;
    end else if (cpu_req || dma_req) begin
      m_who  = (cpu_req && dma_req) ? !m_last : dma_req;
      m_last = m_who;
      m_busy = 1'b1;
      m_age  = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    bit cpu_pend, dma_pend;
    int pr;
    cpu_pend = 1'b0; dma_pend = 1'b0;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    m_busy = 1'b0; m_who = 1'b0; m_last = 1'b1; m_age = 0;
    repeat (2) @(negedge clk);
    cycle();
    reset = 1'b0;

    // Single CPU read with immediate ready
    cpu_req = 1'b1; cpu_addr = 32'h10;
    cycle();
    mem_ready = 1'b1; mem_rdata = 32'hE3A00001;
    #1;
    chk("tp1_done",  64'(cpu_done),  64'(1'b1));
    chk("tp1_rdata", 64'(cpu_rdata), 64'(32'hE3A00001));
    cycle();
    cpu_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    #1;
    chk("tp1_idle", 64'(mem_req), 64'(1'b0));
    cycle();

    // Simultaneous requests after reset alternate CPU, DMA, CPU
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      #1;
      chk("tp2_owner", 64'(owner), 64'(k % 2 == 1));
      chk("tp2_done",  64'((k % 2 == 1) ? dma_done : cpu_done), 64'(1'b1));
      cycle();
    end
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
    cycle();

    // DMA write with ready delayed to the third busy cycle
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hDEADBEEF;
    cycle();
    for (int j = 0; j < 3; j++) begin
      mem_ready = (j == 2);
      #1;
      chk("tp3_we",    64'(mem_we),    64'(1'b1));
      chk("tp3_addr",  64'(mem_addr),  64'(32'h20));
      chk("tp3_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
      chk("tp3_done",  64'(dma_done),  64'(j == 2));
      cycle();
    end
    dma_req = 1'b0; dma_we = 1'b0; mem_ready = 1'b0;
    cycle();

    // CPU read that never sees ready: watchdog fires on the 16th busy cycle
    cpu_req = 1'b1; cpu_addr = 32'h40;
    cycle();
    for (int j = 0; j < int'(TO); j++) begin
      #1;
      chk("tp4_done", 64'(cpu_done), 64'(j == int'(TO) - 1));
      chk("tp4_err",  64'(cpu_err),  64'(j == int'(TO) - 1));
      cycle();
    end
    cpu_req = 1'b0;
    #1;
    chk("tp4_idle", 64'(mem_req), 64'(1'b0));
    cycle();

    // Reset during the second BUSY_DMA cycle
    dma_req = 1'b1; dma_addr = 32'h30;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; dma_req = 1'b0;
    #1;
    chk("tp5_req",  64'(mem_req),  64'(1'b0));
    chk("tp5_done", 64'(dma_done), 64'(1'b0));
    cycle();
    cpu_req = 1'b1; dma_req = 1'b1;
    cycle();
    mem_ready = 1'b1;
    #1;
    chk("tp5_owner", 64'(owner),    64'(1'b0));
    chk("tp5_cpu",   64'(cpu_done), 64'(1'b1));
    cycle();
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
    cycle();

    // mem_ready while idle does nothing
    mem_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("tp6_req",  64'(mem_req),             64'(1'b0));
      chk("tp6_done", 64'(cpu_done | dma_done), 64'(1'b0));
      cycle();
    end
    mem_ready = 1'b0;

    // Random traffic: fast memory first, then a slow one that hits the watchdog
    for (int c = 0; c < 1200; c++) begin
      pr = (c < 600) ? 50 : 6;
      if (!cpu_pend && $urandom_range(99) < 40) begin
        cpu_pend = 1'b1; cpu_req = 1'b1;
        cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      end
      if (!dma_pend && $urandom_range(99) < 40) begin
        dma_pend = 1'b1; dma_req = 1'b1;
        dma_we = 1'($urandom); dma_addr = AW'($urandom); dma_wdata = DW'($urandom);
      end
      mem_ready = ($urandom_range(99) < pr);
      mem_rdata = DW'($urandom);
      reset = ($urandom_range(199) == 0);
      cycle();
      if (reset) begin
        cpu_pend = 1'b0; dma_pend = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0;
        reset = 1'b0;
      end else begin
        if (e_cpu_done) begin cpu_pend = 1'b0; cpu_req = 1'b0; end
        if (e_dma_done) begin dma_pend = 1'b0; dma_req = 1'b0; end
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single unified instruction/data memory of the multicycle core between the CPU and a DMA/debug loader.
- Each requester uses a req/done handshake; the memory side uses a req/ready handshake.
- Ties are resolved round-robin.
- A watchdog aborts any transaction the memory never completes.
- Sits between the core's address mux (AdrSrc path) and the memory model; cpu_done gates the core's state advance out of FETCH/MEMRD/MEMWR.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles in a BUSY state without mem_ready before abort (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
cpu_req  input  1  CPU access request, held until cpu_done
cpu_we  input  1  CPU write enable
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU write data
cpu_rdata  output  DW  CPU read data, valid when cpu_done
cpu_done  output  1  one-cycle completion pulse to CPU
cpu_err  output  1  with cpu_done: transaction timed out
dma_req  input  1  DMA access request, held until dma_done
dma_we  input  1  DMA write enable
dma_addr  input  AW  DMA address
dma_wdata  input  DW  DMA write data
dma_rdata  output  DW  DMA read data, valid when dma_done
dma_done  output  1  one-cycle completion pulse to DMA
dma_err  output  1  with dma_done: transaction timed out
mem_req  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
mem_ready  input  1  memory completes current access this cycle
owner  output  1  current/last grant: 0 = CPU, 1 = DMA

Behaviour:
- States: IDLE, BUSY_CPU, BUSY_DMA. All state is registered on posedge clk.
- Reset (synchronous, also mid-transaction):
  - state = IDLE, last_owner = DMA (so the CPU wins the first tie), watchdog = 0.
  - Outputs: mem_req = 0, all done/err = 0, owner = 1.
- IDLE:
  - Only cpu_req -> BUSY_CPU next cycle.
  - Only dma_req -> BUSY_DMA next cycle.
  - Both -> grant the requester that is not last_owner.
  - Neither -> stay in IDLE.
  - On entering a BUSY state, last_owner is updated to the granted requester.
- BUSY_x:
  - mem_req = 1; mem_we/addr/wdata are combinationally muxed from owner x.
  - mem_ready = 1 -> x_done = 1 the same cycle, x_rdata = mem_rdata (pass-through), next state IDLE.
- Outputs outside BUSY: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- rdata outputs are 0 whenever the corresponding done is 0.
- Minimum latency: req sampled at cycle N, mem_req at N+1, done at N+1 if mem_ready.
  - Back-to-back requests always pass through one IDLE cycle.
  - A req still high in the cycle after done is a new request.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When the count reaches TIMEOUT-1 without ready: x_done = 1, x_err = 1, x_rdata = 0, next state IDLE.
  - mem_ready in that same cycle wins: normal done, no error.
- Requester deasserts req mid-transaction: transaction still completes; done is pulsed regardless.
- mem_ready in IDLE: ignored; no done.
- Requester inputs must be stable while owner; the arbiter does not latch them.
- Exactly one done pulse per granted transaction; cpu_done and dma_done are never high together.

Test Plan:
- Reset, then cpu_req=1 read addr 0x10; memory returns 0xE3A00001 with ready on the first BUSY cycle -> mem_req at cycle 1, cpu_done=1 and cpu_rdata=0xE3A00001 at cycle 1, state IDLE at cycle 2.
- cpu_req and dma_req both high after reset -> CPU granted first. Hold both -> DMA granted next, then CPU: strict alternation, owner toggling 0,1,0.
- DMA write addr 0x20 data 0xDEADBEEF, ready delayed 3 cycles -> mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF held 3 cycles; dma_done on the 3rd.
- CPU read, mem_ready never asserted, TIMEOUT=16 -> cpu_done=1, cpu_err=1 on the 16th BUSY cycle; next cycle IDLE with mem_req=0.
- reset asserted in the 2nd cycle of BUSY_DMA -> next cycle mem_req=0, no dma_done. Then simultaneous requests -> CPU granted.
- mem_ready pulsed while IDLE with no requests -> no done, mem_req stays 0.
